// File: rtl/ex_pkg.sv
// ex_pkg
// Shared types and helpers for the execute stage of the SIMD AES pipeline.
//   alu_op_e        : 3-bit ALU opcode
//   ex_state_e      : multiplier sequencer state
//   GF_POLY_DEFAULT : low byte of the GF(2^8) reduction polynomial x^8+x^4+x^3+x+1
//   xtime()         : multiply one byte by x in GF(2^8)
package ex_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_ROTL  = 3'b101,
        OP_PASSB = 3'b110,
        OP_GMUL  = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

    localparam logic [7:0] GF_POLY_DEFAULT = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] b,
                                         input logic [7:0] poly = GF_POLY_DEFAULT);
        logic [7:0] sh;
        sh = {b[6:0], 1'b0};
        return b[7] ? (sh ^ poly) : sh;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if
// Bundles the ID/EX inputs, the forwarding sources, the stall request and
// the EX/MEM outputs of the execute stage.
//   master : upstream/downstream side (drives EX_* and FW_*, observes MEM_* and stall)
//   slave  : the execute stage itself
interface ex_stage_if;

    logic [31:0] EX_data1;
    logic [31:0] EX_data2;
    logic [31:0] EX_Imm;
    logic [4:0]  EX_rd;
    logic [4:0]  EX_rs1;
    logic [4:0]  EX_rs2;
    logic [2:0]  EX_ALUControl;
    logic        EX_RegWrite;
    logic        EX_MemWrite;
    logic        EX_ALUScr;
    logic        EX_VRegWrite;
    logic        EX_colwrite;
    logic [1:0]  EX_MemToReg;
    logic [1:0]  EX_columna;

    logic [4:0]  FW_mem_rd;
    logic [31:0] FW_mem_data;
    logic        FW_mem_regwrite;
    logic [4:0]  FW_wb_rd;
    logic [31:0] FW_wb_data;
    logic        FW_wb_regwrite;

    logic        stall;
    logic [31:0] MEM_ALUResult;
    logic [31:0] MEM_data2;
    logic [4:0]  MEM_rd;
    logic        MEM_RegWrite;
    logic        MEM_MemWrite;
    logic        MEM_VRegWrite;
    logic        MEM_colwrite;
    logic [1:0]  MEM_MemToReg;
    logic [1:0]  MEM_columna;

    modport master (
        output EX_data1, EX_data2, EX_Imm, EX_rd, EX_rs1, EX_rs2, EX_ALUControl,
               EX_RegWrite, EX_MemWrite, EX_ALUScr, EX_VRegWrite, EX_colwrite,
               EX_MemToReg, EX_columna,
               FW_mem_rd, FW_mem_data, FW_mem_regwrite,
               FW_wb_rd, FW_wb_data, FW_wb_regwrite,
        input  stall, MEM_ALUResult, MEM_data2, MEM_rd, MEM_RegWrite, MEM_MemWrite,
               MEM_VRegWrite, MEM_colwrite, MEM_MemToReg, MEM_columna
    );

    modport slave (
        input  EX_data1, EX_data2, EX_Imm, EX_rd, EX_rs1, EX_rs2, EX_ALUControl,
               EX_RegWrite, EX_MemWrite, EX_ALUScr, EX_VRegWrite, EX_colwrite,
               EX_MemToReg, EX_columna,
               FW_mem_rd, FW_mem_data, FW_mem_regwrite,
               FW_wb_rd, FW_wb_data, FW_wb_regwrite,
        output stall, MEM_ALUResult, MEM_data2, MEM_rd, MEM_RegWrite, MEM_MemWrite,
               MEM_VRegWrite, MEM_colwrite, MEM_MemToReg, MEM_columna
    );

endinterface

// File: rtl/ex_gmul_unit.sv
// ex_gmul_unit
// Four-lane iterative GF(2^8) multiplier. Each byte lane runs the classic
// shift-and-add loop, one bit of B per clock; the eighth step is computed
// combinationally so the result is ready in the cnt==7 cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : begin a multiply (accepted only when idle)
//   i_a, i_b   : four packed byte operands
//   o_busy     : sequencer is in MUL
//   o_last     : final step; o_result is valid this cycle
//   o_result   : four packed byte products
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for i_start; operands latched on start
// ST_MUL  | one shift-and-add step per cycle, cnt 0..7; cnt 7 is last
module ex_gmul_unit
    import ex_pkg::*;
#(
    parameter logic [7:0] GF_POLY = GF_POLY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_last,
    output logic [31:0] o_result
);

    ex_state_e   r_state;
    ex_state_e   w_state_nxt;
    logic [2:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_acc;
    logic [31:0] w_a_step;
    logic [31:0] w_b_step;
    logic [31:0] w_acc_step;
    logic        w_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start)      w_state_nxt = ST_MUL;
            ST_MUL:  if (r_cnt == 3'd7) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (r_state == ST_MUL);
        o_last  = (r_state == ST_MUL) && (r_cnt == 3'd7);
        w_issue = (r_state == ST_IDLE) && i_start;
    end

    always_comb begin
        w_a_step   = '0;
        w_b_step   = '0;
        w_acc_step = '0;
        for (int l = 0; l < 4; l++) begin
            w_acc_step[8*l +: 8] = r_acc[8*l +: 8] ^ (r_b[8*l] ? r_a[8*l +: 8] : 8'h00);
            w_a_step[8*l +: 8]   = xtime(r_a[8*l +: 8], GF_POLY);
            w_b_step[8*l +: 8]   = {1'b0, r_b[8*l+1 +: 7]};
        end
    end

    // The eighth accumulate is the result; no extra register stage.
    assign o_result = w_acc_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 3'd0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (w_issue) begin
            r_cnt <= 3'd0;
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
        end else if (r_state == ST_MUL) begin
            r_cnt <= r_cnt + 3'd1;
            r_a   <= w_a_step;
            r_b   <= w_b_step;
            r_acc <= w_acc_step;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage
// Execute stage of the SIMD AES pipeline: operand forwarding, single-cycle
// ALU, iterative GF(2^8) multiply and the EX/MEM output registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ex_stage_if.slave (EX_* in, FW_* in, stall out, MEM_* out)
// Build option: define EX_FORWARD_EN to include the MEM/WB forwarding muxes;
// without it operands come straight from EX_data1/EX_data2 and FW_* is unused.
module ex_stage
    import ex_pkg::*;
#(
    parameter logic [7:0] GF_POLY = GF_POLY_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);

    alu_op_e     w_op;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_alu;
    logic        w_is_gmul;
    logic        w_start;
    logic        w_busy;
    logic        w_last;
    logic [31:0] w_gmul_res;

    logic [31:0] r_lat_data2;
    logic [4:0]  r_lat_rd;
    logic        r_lat_regwrite;
    logic        r_lat_memwrite;
    logic        r_lat_vregwrite;
    logic        r_lat_colwrite;
    logic [1:0]  r_lat_memtoreg;
    logic [1:0]  r_lat_columna;

    assign w_op = alu_op_e'(bus.EX_ALUControl);

`ifdef EX_FORWARD_EN
    function automatic logic [31:0] fwd_sel(input logic [4:0]  rs,
                                            input logic [31:0] rf_val,
                                            input logic        mem_we,
                                            input logic [4:0]  mem_rd,
                                            input logic [31:0] mem_data,
                                            input logic        wb_we,
                                            input logic [4:0]  wb_rd,
                                            input logic [31:0] wb_data);
        // MEM is the younger producer, so it wins over WB.
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) return mem_data;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))    return wb_data;
        return rf_val;
    endfunction

    always_comb begin
        w_rs1_val = fwd_sel(bus.EX_rs1, bus.EX_data1,
                            bus.FW_mem_regwrite, bus.FW_mem_rd, bus.FW_mem_data,
                            bus.FW_wb_regwrite, bus.FW_wb_rd, bus.FW_wb_data);
        w_rs2_val = fwd_sel(bus.EX_rs2, bus.EX_data2,
                            bus.FW_mem_regwrite, bus.FW_mem_rd, bus.FW_mem_data,
                            bus.FW_wb_regwrite, bus.FW_wb_rd, bus.FW_wb_data);
    end
`else
    assign w_rs1_val = bus.EX_data1;
    assign w_rs2_val = bus.EX_data2;
`endif

    assign w_a = w_rs1_val;
    assign w_b = bus.EX_ALUScr ? bus.EX_Imm : w_rs2_val;

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:   w_alu = w_a + w_b;
            OP_SUB:   w_alu = w_a - w_b;
            OP_AND:   w_alu = w_a & w_b;
            OP_OR:    w_alu = w_a | w_b;
            OP_XOR:   w_alu = w_a ^ w_b;
            OP_ROTL: begin
                case (w_b[1:0])
                    2'd0:    w_alu = w_a;
                    2'd1:    w_alu = {w_a[23:0], w_a[31:24]};
                    2'd2:    w_alu = {w_a[15:0], w_a[31:16]};
                    default: w_alu = {w_a[7:0],  w_a[31:8]};
                endcase
            end
            OP_PASSB: w_alu = w_b;
            default:  w_alu = '0;
        endcase
    end

    assign w_is_gmul = (w_op == OP_GMUL);
    assign w_start   = !w_busy && w_is_gmul;
    assign bus.stall = w_start || (w_busy && !w_last);

    ex_gmul_unit #(
        .GF_POLY (GF_POLY)
    ) u_gmul (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_busy   (w_busy),
        .o_last   (w_last),
        .o_result (w_gmul_res)
    );

    // Forwarded operands and control are captured at issue; the EX_* and
    // FW_* inputs are don't-care for the rest of the multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_data2     <= '0;
            r_lat_rd        <= '0;
            r_lat_regwrite  <= 1'b0;
            r_lat_memwrite  <= 1'b0;
            r_lat_vregwrite <= 1'b0;
            r_lat_colwrite  <= 1'b0;
            r_lat_memtoreg  <= '0;
            r_lat_columna   <= '0;
        end else if (w_start) begin
            r_lat_data2     <= w_rs2_val;
            r_lat_rd        <= bus.EX_rd;
            r_lat_regwrite  <= bus.EX_RegWrite;
            r_lat_memwrite  <= bus.EX_MemWrite;
            r_lat_vregwrite <= bus.EX_VRegWrite;
            r_lat_colwrite  <= bus.EX_colwrite;
            r_lat_memtoreg  <= bus.EX_MemToReg;
            r_lat_columna   <= bus.EX_columna;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.MEM_ALUResult <= '0;
            bus.MEM_data2     <= '0;
            bus.MEM_rd        <= '0;
            bus.MEM_RegWrite  <= 1'b0;
            bus.MEM_MemWrite  <= 1'b0;
            bus.MEM_VRegWrite <= 1'b0;
            bus.MEM_colwrite  <= 1'b0;
            bus.MEM_MemToReg  <= '0;
            bus.MEM_columna   <= '0;
        end else if (w_last) begin
            bus.MEM_ALUResult <= w_gmul_res;
            bus.MEM_data2     <= r_lat_data2;
            bus.MEM_rd        <= r_lat_rd;
            bus.MEM_RegWrite  <= r_lat_regwrite;
            bus.MEM_MemWrite  <= r_lat_memwrite;
            bus.MEM_VRegWrite <= r_lat_vregwrite;
            bus.MEM_colwrite  <= r_lat_colwrite;
            bus.MEM_MemToReg  <= r_lat_memtoreg;
            bus.MEM_columna   <= r_lat_columna;
        end else if (w_busy || w_is_gmul) begin
            // Bubble: kill the side-effect bits, leave the data fields alone.
            bus.MEM_RegWrite  <= 1'b0;
            bus.MEM_MemWrite  <= 1'b0;
            bus.MEM_VRegWrite <= 1'b0;
            bus.MEM_colwrite  <= 1'b0;
        end else begin
            bus.MEM_ALUResult <= w_alu;
            bus.MEM_data2     <= w_rs2_val;
            bus.MEM_rd        <= bus.EX_rd;
            bus.MEM_RegWrite  <= bus.EX_RegWrite;
            bus.MEM_MemWrite  <= bus.EX_MemWrite;
            bus.MEM_VRegWrite <= bus.EX_VRegWrite;
            bus.MEM_colwrite  <= bus.EX_colwrite;
            bus.MEM_MemToReg  <= bus.EX_MemToReg;
            bus.MEM_columna   <= bus.EX_columna;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage
// Self-checking bench for ex_stage: directed cases plus randomized
// single-cycle and gmul instructions against a behavioural model.
module tb_ex_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    ex_stage_if bus ();

    ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected EX/MEM register contents.
    logic [31:0] e_res, e_d2;
    logic [4:0]  e_rd;
    logic        e_rw, e_mw, e_vw, e_cw;
    logic [1:0]  e_m2r, e_col;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input string tag);
        chk({tag, "_res"},  bus.MEM_ALUResult, e_res);
        chk({tag, "_d2"},   bus.MEM_data2,     e_d2);
        chk({tag, "_rd"},   {27'd0, bus.MEM_rd}, {27'd0, e_rd});
        chk({tag, "_ctl"},  {24'd0, bus.MEM_RegWrite, bus.MEM_MemWrite, bus.MEM_VRegWrite,
                             bus.MEM_colwrite, bus.MEM_MemToReg, bus.MEM_columna},
                            {24'd0, e_rw, e_mw, e_vw, e_cw, e_m2r, e_col});
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] dflt);
`ifdef EX_FORWARD_EN
        if (bus.FW_mem_regwrite && bus.FW_mem_rd != 5'd0 && bus.FW_mem_rd == rs)
            return bus.FW_mem_data;
        if (bus.FW_wb_regwrite && bus.FW_wb_rd != 5'd0 && bus.FW_wb_rd == rs)
            return bus.FW_wb_data;
`endif
        return dflt;
    endfunction

    // Carry-less product then reduction modulo x^8 + poly.
    function automatic logic [7:0] gf_mul_ref(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        logic [15:0] m;
        p = 16'd0;
        for (int i = 0; i < 8; i++)
            if (y[i]) p = p ^ ({8'd0, x} << i);
        for (int i = 15; i >= 8; i--) begin
            m = {7'd0, 1'b1, 8'h1B} << (i - 8);
            if (p[i]) p = p ^ m;
        end
        return p[7:0];
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                r = a;
                for (int k = 0; k < int'(b[1:0]); k++) r = {r[23:0], r[31:24]};
            end
            3'd6: r = b;
            default: begin
                r = '0;
                for (int l = 0; l < 4; l++)
                    r[8*l +: 8] = gf_mul_ref(a[8*l +: 8], b[8*l +: 8]);
            end
        endcase
        return r;
    endfunction

    task automatic rand_inputs(input bit allow_gmul);
        bus.EX_data1        = $urandom;
        bus.EX_data2        = $urandom;
        bus.EX_Imm          = $urandom;
        bus.EX_rd           = 5'($urandom);
        bus.EX_rs1          = 5'($urandom_range(0, 3));
        bus.EX_rs2          = 5'($urandom_range(0, 3));
        bus.EX_ALUControl   = allow_gmul ? 3'($urandom) : 3'($urandom_range(0, 6));
        bus.EX_RegWrite     = 1'($urandom);
        bus.EX_MemWrite     = 1'($urandom);
        bus.EX_ALUScr       = 1'($urandom);
        bus.EX_VRegWrite    = 1'($urandom);
        bus.EX_colwrite     = 1'($urandom);
        bus.EX_MemToReg     = 2'($urandom);
        bus.EX_columna      = 2'($urandom);
        bus.FW_mem_rd       = 5'($urandom_range(0, 3));
        bus.FW_mem_data     = $urandom;
        bus.FW_mem_regwrite = 1'($urandom);
        bus.FW_wb_rd        = 5'($urandom_range(0, 3));
        bus.FW_wb_data      = $urandom;
        bus.FW_wb_regwrite  = 1'($urandom);
    endtask

    // Inputs already driven (op != 111, stage idle); called at posedge+1.
    task automatic step_single(input string tag);
        logic [31:0] a, b, d2;
        d2 = fwd(bus.EX_rs2, bus.EX_data2);
        a  = fwd(bus.EX_rs1, bus.EX_data1);
        b  = bus.EX_ALUScr ? bus.EX_Imm : d2;
        #3;
        chk({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
        e_res = ref_alu(bus.EX_ALUControl, a, b);
        e_d2 = d2; e_rd = bus.EX_rd;
        e_rw = bus.EX_RegWrite; e_mw = bus.EX_MemWrite;
        e_vw = bus.EX_VRegWrite; e_cw = bus.EX_colwrite;
        e_m2r = bus.EX_MemToReg; e_col = bus.EX_columna;
        @(posedge clk); #1;
        chk_mem(tag);
    endtask

    // gmul already driven; junk is driven while it runs. Returns stall cycles seen.
    task automatic run_gmul(input string tag, output int stalls);
        logic [31:0] a, b, d2, res;
        logic [4:0]  rd;
        logic [7:0]  ctl;
        d2  = fwd(bus.EX_rs2, bus.EX_data2);
        a   = fwd(bus.EX_rs1, bus.EX_data1);
        b   = bus.EX_ALUScr ? bus.EX_Imm : d2;
        res = ref_alu(3'd7, a, b);
        rd  = bus.EX_rd;
        ctl = {bus.EX_RegWrite, bus.EX_MemWrite, bus.EX_VRegWrite, bus.EX_colwrite,
               bus.EX_MemToReg, bus.EX_columna};
        stalls = 0;
        for (int c = 0; c < 8; c++) begin
            #3;
            chk({tag, "_stall_hi"}, {31'd0, bus.stall}, 32'd1);
            if (bus.stall) stalls++;
            @(posedge clk); #1;
            e_rw = 1'b0; e_mw = 1'b0; e_vw = 1'b0; e_cw = 1'b0;
            chk_mem({tag, "_bubble"});
            rand_inputs(1'b1);
        end
        #3;
        chk({tag, "_stall_lo"}, {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        e_res = res; e_d2 = d2; e_rd = rd;
        {e_rw, e_mw, e_vw, e_cw, e_m2r, e_col} = ctl;
        chk_mem({tag, "_done"});
    endtask

    task automatic clear_inputs();
        bus.EX_data1 = '0; bus.EX_data2 = '0; bus.EX_Imm = '0;
        bus.EX_rd = '0; bus.EX_rs1 = '0; bus.EX_rs2 = '0;
        bus.EX_ALUControl = 3'd0;
        bus.EX_RegWrite = 1'b0; bus.EX_MemWrite = 1'b0; bus.EX_ALUScr = 1'b0;
        bus.EX_VRegWrite = 1'b0; bus.EX_colwrite = 1'b0;
        bus.EX_MemToReg = '0; bus.EX_columna = '0;
        bus.FW_mem_rd = '0; bus.FW_mem_data = '0; bus.FW_mem_regwrite = 1'b0;
        bus.FW_wb_rd = '0; bus.FW_wb_data = '0; bus.FW_wb_regwrite = 1'b0;
    endtask

    task automatic zero_exp();
        e_res = '0; e_d2 = '0; e_rd = '0;
        e_rw = 1'b0; e_mw = 1'b0; e_vw = 1'b0; e_cw = 1'b0;
        e_m2r = '0; e_col = '0;
    endtask

    initial begin
        int s1, s2;
        clear_inputs();
        zero_exp();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'd0, bus.stall}, 32'd0);
        chk_mem("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // add, no hazards
        bus.EX_data1 = 32'h0000_0005; bus.EX_data2 = 32'hFFFF_FFFE;
        bus.EX_rs1 = 5'd1; bus.EX_rs2 = 5'd2; bus.EX_rd = 5'd7;
        bus.EX_RegWrite = 1'b1; bus.EX_ALUControl = 3'd0;
        step_single("add");
        chk("add_kat", bus.MEM_ALUResult, 32'h0000_0003);

        // forwarding priority
        bus.EX_rs1 = 5'd3; bus.EX_rs2 = 5'd3; bus.EX_data1 = 32'h44; bus.EX_data2 = 32'h33;
        bus.EX_ALUControl = 3'd6; bus.EX_ALUScr = 1'b0;
        bus.FW_mem_rd = 5'd3; bus.FW_mem_data = 32'h11; bus.FW_mem_regwrite = 1'b1;
        bus.FW_wb_rd  = 5'd3; bus.FW_wb_data  = 32'h22; bus.FW_wb_regwrite  = 1'b1;
        step_single("fwd_both");
`ifdef EX_FORWARD_EN
        chk("fwd_both_kat", bus.MEM_ALUResult, 32'h11);
`else
        chk("fwd_both_kat", bus.MEM_ALUResult, 32'h33);
`endif
        bus.FW_mem_regwrite = 1'b0;
        step_single("fwd_wb");
        bus.FW_mem_regwrite = 1'b1; bus.FW_mem_rd = 5'd0; bus.FW_wb_rd = 5'd0;
        step_single("fwd_rd0");
        chk("fwd_rd0_kat", bus.MEM_ALUResult, 32'h33);

        // rotl
        clear_inputs();
        bus.EX_data1 = 32'hAABB_CCDD; bus.EX_Imm = 32'd1; bus.EX_ALUScr = 1'b1;
        bus.EX_ALUControl = 3'd5; bus.EX_rd = 5'd9;
        step_single("rotl");
        chk("rotl_kat", bus.MEM_ALUResult, 32'hBBCC_DDAA);

        // directed gmul
        clear_inputs();
        bus.EX_data1 = 32'h5757_5757; bus.EX_Imm = 32'h8313_0201; bus.EX_ALUScr = 1'b1;
        bus.EX_ALUControl = 3'd7; bus.EX_rd = 5'd12; bus.EX_RegWrite = 1'b1;
        run_gmul("gmul", s1);
        chk("gmul_kat", bus.MEM_ALUResult, 32'hC1FE_AE57);

        // random single-cycle traffic
        for (int i = 0; i < 40; i++) begin
            rand_inputs(1'b0);
            step_single("rnd");
        end

        // back-to-back random gmul
        rand_inputs(1'b0);
        bus.EX_ALUControl = 3'd7; bus.EX_rd = 5'd20;
        run_gmul("b2b_first", s1);
        chk("b2b_rd1", {27'd0, bus.MEM_rd}, 32'd20);
        rand_inputs(1'b0);
        bus.EX_ALUControl = 3'd7; bus.EX_rd = 5'd21;
        run_gmul("b2b_second", s2);
        chk("b2b_rd2", {27'd0, bus.MEM_rd}, 32'd21);
        chk("b2b_stall_total", s1 + s2, 32'd16);

        // interleaved random traffic with gmul
        for (int i = 0; i < 6; i++) begin
            rand_inputs(1'b0);
            step_single("mix_single");
            rand_inputs(1'b0);
            bus.EX_ALUControl = 3'd7;
            run_gmul("mix_gmul", s1);
        end

        // reset in the middle of a multiply (cnt == 4)
        rand_inputs(1'b0);
        bus.EX_ALUControl = 3'd7;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #1;
        chk("midmul_stall_pre", {31'd0, bus.stall}, 32'd1);
        bus.EX_ALUControl = 3'd0;
        rst_n = 1'b0;
        #1;
        zero_exp();
        chk("midmul_rst_stall", {31'd0, bus.stall}, 32'd0);
        chk_mem("midmul_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_stall", {31'd0, bus.stall}, 32'd0);
        clear_inputs();
        bus.EX_data1 = 32'h1234_0000; bus.EX_data2 = 32'h0000_5678;
        bus.EX_rd = 5'd4; bus.EX_RegWrite = 1'b1;
        step_single("post_rst_add");
        chk("post_rst_add_kat", bus.MEM_ALUResult, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
